// File: rtl/ticket_server_if.sv
// ticket_server_if
//   Bundles the client-facing signals of the take-a-number server.
//   Ports (seen from the slave = server side):
//     req        in   HIPROC+1  per-client ticket request
//     rel        in   HIPROC+1  per-client release of the critical section
//     grant      out  HIPROC+1  one-hot-or-zero critical-section grant
//     nowServing out  TKMSB+1   ticket currently being called
//     nextTicket out  TKMSB+1   ticket the next issue hands out
//     holders    out  SELMSB+1  clients currently WAITING or SERVED
//
// Handshake: there is no valid/ready pair. A client holds req high until it
// sees its ticket taken (it leaves IDLE), then waits for grant; it pulses
// rel while granted to leave. Inputs are level-sampled on each posedge and
// only honoured in the client state noted above; all outputs are registered.
interface ticket_server_if #(
  parameter int TKMSB  = 2,
  parameter int HIPROC = 1,
  parameter int SELMSB = 1
);
  logic [HIPROC:0] req;
  logic [HIPROC:0] rel;
  logic [HIPROC:0] grant;
  logic [TKMSB:0]  nowServing;
  logic [TKMSB:0]  nextTicket;
  logic [SELMSB:0] holders;

  // master = client side (drives requests), slave = server side
  modport master (
    output req,
    output rel,
    input  grant,
    input  nowServing,
    input  nextTicket,
    input  holders
  );

  modport slave (
    input  req,
    input  rel,
    output grant,
    output nowServing,
    output nextTicket,
    output holders
  );
endinterface

// File: rtl/ticket_server.sv
// ticket_server
//   Central take-a-number server. Clients request a ticket, the server hands
//   out wrapping ticket numbers, and calls exactly one ticket holder at a
//   time into the critical section, strictly in ticket order.
//   Ports:
//     clock      in   single clock, all state changes on posedge
//     reset      in   synchronous active-high reset, overrides everything
//     bus        slave modport of ticket_server_if (req/rel in, grant,
//                nowServing, nextTicket, holders out)
//     state_dbg  out  per-client state, 2 bits per client, client i at
//                [2*i +: 2] (0 = IDLE, 1 = WAITING, 2 = SERVED)
module ticket_server #(
  parameter int TKMSB  = 2,
  parameter int HIPROC = 1,
  parameter int SELMSB = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  ticket_server_if.slave           bus,
  output logic [2*(HIPROC+1)-1:0]  state_dbg
);

  localparam int TKW = TKMSB + 1;
  localparam int HW  = SELMSB + 1;
  localparam int NC  = HIPROC + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SERVED  = 2'd2
  } client_state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  client_state_t  state_q [NC];
  client_state_t  state_d [NC];
  logic [TKMSB:0] tk_q    [NC];
  logic [TKMSB:0] tk_d    [NC];

  logic [TKMSB:0]  next_q, next_d;
  logic [TKMSB:0]  now_q,  now_d;
  logic [HIPROC:0] grant_q, grant_d;
  logic [SELMSB:0] holders_q, holders_d;

  // Per-cycle event decode, all derived from start-of-cycle state
  logic [HIPROC:0] issue_oh;
  logic [HIPROC:0] call_oh;
  logic [HIPROC:0] rel_oh;
  logic            served_any;
  logic            issue_found;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        state_q[i] <= IDLE;
        tk_q[i]    <= '0;
      end
      next_q    <= '0;
      now_q     <= '0;
      grant_q   <= '0;
      holders_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        state_q[i] <= state_d[i];
        tk_q[i]    <= tk_d[i];
      end
      next_q    <= next_d;
      now_q     <= now_d;
      grant_q   <= grant_d;
      holders_q <= holders_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      state_d[i] = state_q[i];
      tk_d[i]    = tk_q[i];
    end
    next_d      = next_q;
    now_d       = now_q;
    grant_d     = '0;
    holders_d   = '0;
    issue_oh    = '0;
    call_oh     = '0;
    rel_oh      = '0;
    served_any  = 1'b0;
    issue_found = 1'b0;

    for (int i = 0; i < NC; i++) begin
      if (state_q[i] == SERVED) served_any = 1'b1;
    end

    // Issue: lowest-index IDLE requester wins; others retry next cycle.
    for (int i = 0; i < NC; i++) begin
      if (!issue_found && state_q[i] == IDLE && bus.req[i]) begin
        issue_oh[i] = 1'b1;
        issue_found = 1'b1;
      end
    end

    // Call only into an empty critical section. Tickets are unique among
    // holders, so at most one WAITING client can match nowServing. Pure
    // equality keeps wrap-around from reordering service.
    for (int i = 0; i < NC; i++) begin
      call_oh[i] = !served_any && state_q[i] == WAITING && tk_q[i] == now_q;
      rel_oh[i]  = state_q[i] == SERVED && bus.rel[i];
    end

    // The three events touch disjoint source states (IDLE, WAITING,
    // SERVED), so a client sees at most one of them. A SERVED client that
    // asserts req and rel together only releases: issue looks at IDLE as
    // of the start of the cycle.
    for (int i = 0; i < NC; i++) begin
      if (rel_oh[i]) begin
        state_d[i] = IDLE;
      end else if (issue_oh[i]) begin
        state_d[i] = WAITING;
        tk_d[i]    = next_q;
      end else if (call_oh[i]) begin
        state_d[i] = SERVED;
      end
    end

    if (issue_found) next_d = next_q + TKW'(1);
    if (|rel_oh)     now_d  = now_q + TKW'(1);

    // grant and holders are registered views of the next state, so they
    // change in the same update as the client states they describe.
    for (int i = 0; i < NC; i++) begin
      grant_d[i] = (state_d[i] == SERVED);
      if (state_d[i] != IDLE) holders_d = holders_d + HW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.grant      = grant_q;
  assign bus.nowServing = now_q;
  assign bus.nextTicket = next_q;
  assign bus.holders    = holders_q;

  for (genvar g = 0; g < NC; g++) begin : g_dbg
    assign state_dbg[2*g +: 2] = state_q[g];
  end

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  // Outstanding tickets equal the holder count; the widths differ, so both
  // sides are compared modulo the ticket space.
  logic [TKMSB:0] holders_tk;
  assign holders_tk = TKW'(holders_q);

  a_grant_onehot0 : assert property (@(posedge clock) disable iff (reset)
    $onehot0(grant_q));

  a_holders_count : assert property (@(posedge clock) disable iff (reset)
    (next_q - now_q) == holders_tk);

  for (genvar g = 0; g < NC; g++) begin : g_served_tk
    a_served_tk : assert property (@(posedge clock) disable iff (reset)
      (state_q[g] == SERVED) |-> (tk_q[g] == now_q));
  end

endmodule

// File: tb/tb_ticket_server.sv
module tb_ticket_server;

  localparam int TKMSB  = 2;
  localparam int HIPROC = 1;
  localparam int SELMSB = 1;
  localparam int NC     = HIPROC + 1;
  localparam int NT     = 1 << (TKMSB + 1);
  localparam int GW     = HIPROC + 1;
  localparam int TW     = TKMSB + 1;
  localparam int HW     = SELMSB + 1;
  localparam int W      = GW + 2*TW + HW;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ticket_server_if #(.TKMSB(TKMSB), .HIPROC(HIPROC), .SELMSB(SELMSB)) bus ();
  logic [2*NC-1:0] state_dbg;

  ticket_server #(.TKMSB(TKMSB), .HIPROC(HIPROC), .SELMSB(SELMSB)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------
  // Reference model: a FIFO of waiting clients in ticket order plus the
  // one client (if any) in the critical section.
  // ---------------------------------------------------------------------
  int m_served = -1;
  int m_next   = 0;
  int m_now    = 0;
  int wq[$];   // waiting clients, oldest ticket first
  int tq[$];   // their tickets

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void model_step(logic [HIPROC:0] r, logic [HIPROC:0] l, bit rs);
    int s0;
    int winner;
    bit busy;
    bit do_call;
    if (rs) begin
      m_served = -1;
      m_next   = 0;
      m_now    = 0;
      wq.delete();
      tq.delete();
      return;
    end
    s0      = m_served;
    do_call = (s0 < 0) && (wq.size() > 0) && (tq[0] == m_now);
    // winner judged on start-of-cycle membership
    winner = -1;
    for (int i = 0; i < NC; i++) begin
      busy = (i == s0);
      foreach (wq[k]) if (wq[k] == i) busy = 1'b1;
      if (winner < 0 && r[i] && !busy) winner = i;
    end
    if (s0 >= 0 && l[s0]) begin
      m_served = -1;
      m_now    = (m_now + 1) % NT;
    end
    if (do_call) begin
      m_served = wq.pop_front();
      void'(tq.pop_front());
    end
    if (winner >= 0) begin
      wq.push_back(winner);
      tq.push_back(m_next);
      m_next = (m_next + 1) % NT;
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [GW-1:0] g;
    logic [TW-1:0] nw;
    logic [TW-1:0] nx;
    logic [HW-1:0] h;
    g = '0;
    if (m_served >= 0) g[m_served] = 1'b1;
    nw = TW'(m_now);
    nx = TW'(m_next);
    h  = HW'(wq.size() + ((m_served >= 0) ? 1 : 0));
    return {g, nw, nx, h};
  endfunction

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic cycle(input logic [HIPROC:0] r, input logic [HIPROC:0] l, input bit rs);
    @(negedge clock);
    bus.req = r;
    bus.rel = l;
    reset   = rs;
    @(posedge clock);
    model_step(r, l, rs);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  task automatic check_field(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_field("grant",      int'(bus.grant),      int'(e[W-1 -: GW]));
      check_field("nowServing", int'(bus.nowServing), int'(e[HW+TW +: TW]));
      check_field("nextTicket", int'(bus.nextTicket), int'(e[HW +: TW]));
      check_field("holders",    int'(bus.holders),    int'(e[0 +: HW]));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [HIPROC:0] r;
    logic [HIPROC:0] l;
    int drain;
    bus.req = '0;
    bus.rel = '0;

    // reset with random req/rel noise
    for (int i = 0; i < 3; i++) cycle(HIPROC'($urandom), HIPROC'($urandom), 1'b1);

    // single client: request, grant after 2 cycles, release
    cycle(2'b01, 2'b00, 1'b0);
    idle(2);
    cycle(2'b00, 2'b01, 1'b0);
    idle(1);

    // simultaneous request, release client 0 -> one-cycle bubble -> client 1
    cycle(2'b11, 2'b00, 1'b0);
    cycle(2'b11, 2'b00, 1'b0);
    idle(2);
    cycle(2'b00, 2'b01, 1'b0);
    idle(2);
    cycle(2'b00, 2'b10, 1'b0);
    idle(1);

    // wrap-around: enough rounds to pass 7 -> 0 and issue ticket 0 again
    for (int k = 0; k < 9; k++) begin
      cycle(2'b01, 2'b00, 1'b0);
      idle(2);
      cycle(2'b00, 2'b01, 1'b0);
    end
    idle(1);

    // ignored inputs: client 0 served, client 1 waiting
    cycle(2'b01, 2'b00, 1'b0);
    idle(1);
    cycle(2'b10, 2'b00, 1'b0);
    cycle(2'b00, 2'b10, 1'b0);   // rel on a WAITING client
    cycle(2'b01, 2'b00, 1'b0);   // req on the SERVED client
    cycle(2'b01, 2'b01, 1'b0);   // req+rel on SERVED: release only
    idle(3);
    cycle(2'b00, 2'b10, 1'b0);
    idle(1);

    // reset while client 1 is served
    cycle(2'b10, 2'b00, 1'b0);
    idle(2);
    cycle(2'b11, 2'b01, 1'b1);
    idle(2);

    // randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      r = HIPROC'($urandom_range(0, (1 << NC) - 1));
      l = ($urandom_range(0, 3) == 0) ? HIPROC'($urandom_range(0, (1 << NC) - 1)) : '0;
      cycle(r, l, ($urandom_range(0, 199) == 0));
    end
    idle(2);

    // bounded drain of the expected queue
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clock);
      drain++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ticket_server.md
# ticket_server

Centralized take-a-number server for the bakery mutual-exclusion models. It is the dispensing and calling side of the ticket protocol that bakery clients otherwise compute among themselves. Clients request a ticket. The server hands out strictly increasing, wrapping ticket numbers and holds a "now serving" counter. It grants the critical section to exactly one ticket holder at a time, in ticket order. Clients are driven by nondeterministic `req`/`rel` inputs, so model checking can verify mutual exclusion and FIFO service of the central scheme.

## Interface
- `TKMSB`, default 2: MSB of ticket numbers; tickets are modulo 2^(TKMSB+1).
- `HIPROC`, default 1: highest client index; indices start at 0. Constraint: HIPROC+1 <= 2^(TKMSB+1).
- `SELMSB`, default 1: MSB of client-count values; must be wide enough to represent HIPROC+1.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `req` input HIPROC+1: per-client ticket request; honoured only when that client is IDLE.
- `rel` input HIPROC+1: per-client release of the critical section; honoured only when that client is SERVED.
- `grant` output HIPROC+1: registered; bit i = client i is in its critical section. At most one bit is set.
- `nowServing` output TKMSB+1: ticket currently being called.
- `nextTicket` output TKMSB+1: ticket the next issue will hand out.
- `holders` output SELMSB+1: number of clients in WAITING or SERVED.

## Operation
- Per-client state is one of IDLE, WAITING or SERVED. Each client also stores a ticket register `tk[i]` of TKMSB+1 bits.
- Reset, with `reset`=1 at a posedge:
  - all clients go to IDLE and all `tk[i]` go to 0;
  - `nextTicket`=0, `nowServing`=0, `grant`=0, `holders`=0.
  - `reset` overrides all other inputs in that cycle, including mid-service; no ticket survives reset.
- Issue, at most one per cycle:
  - Among clients that are IDLE with `req[i]`=1, the lowest index i wins.
  - The winner sets `tk[i]`=`nextTicket` and goes IDLE->WAITING; `nextTicket` increments modulo 2^(TKMSB+1).
  - Losing requesters stay IDLE and must keep `req` high to retry.
- Call:
  - Applies only when no client was SERVED at the start of the cycle.
  - The WAITING client with `tk[i]`==`nowServing` goes WAITING->SERVED and its `grant[i]` rises.
  - Ticket uniqueness, which follows from the HIPROC constraint, guarantees at most one match.
  - Ticket comparison is equality only, so wrap-around never reorders service.
- Release:
  - The SERVED client with `rel[i]`=1 goes SERVED->IDLE and `grant[i]` falls.
  - `nowServing` increments modulo 2^(TKMSB+1) in the same update.
- Ignored inputs:
  - `rel` on a non-SERVED client has no effect.
  - `req` on a non-IDLE client has no effect.
  - `req` and `rel` together on the SERVED client: only the release takes effect, and the client must re-assert `req` on a later cycle.
- Same-cycle combinations:
  - Issue and release in the same cycle are independent and both take effect.
  - Issue and call never involve the same client in the same cycle.
- `holders` is the registered count of WAITING plus SERVED clients, updated in the same cycle as the state changes.
- Invariants, to be asserted in formal runs:
  - onehot0(`grant`);
  - `holders` == (`nextTicket` - `nowServing`) mod 2^(TKMSB+1);
  - SERVED client i implies `tk[i]`==`nowServing`.

## Timing
- `req[i]` high at edge t, client i wins: WAITING and `nextTicket`+1 visible after t. If the server is idle and `tk[i]`==`nowServing`, `grant[i]`=1 after edge t+1. Minimum request-to-grant is 2 cycles.
- `rel[i]` high at edge t: `grant[i]`=0 and `nowServing`+1 after t. The next holder's grant rises after edge t+1, a fixed one-cycle bubble with all grants low.
- All outputs come directly from registers; there are no combinational input-to-output paths.
- With no requests and no releases, all state holds indefinitely.

## Test plan
- Reset: drive random `req`/`rel` with `reset`=1 -> after the edge `grant`=0, `nowServing`=0, `nextTicket`=0, `holders`=0. Assert `reset` while client 1 is SERVED -> everything returns to these values next cycle.
- Single client: `req`=01 for one cycle at t -> `nextTicket`=1, `holders`=1 after t; `grant`=01 after t+1. `rel`=01 at t+3 -> `grant`=00, `nowServing`=1, `holders`=0 after t+3.
- Simultaneous request: `req`=11 held -> client 0 gets ticket 0 at t and client 1 gets ticket 1 at t+1; `grant`=01 after t+1; `holders`=2. Release client 0 -> `grant`=00 for one cycle, then `grant`=10.
- Wrap-around: cycle a single client through 8 grant/release rounds -> `nextTicket` and `nowServing` go 7->0, and the 9th request is granted with `tk`=0 at the normal 2-cycle latency.
- Ignored inputs: `rel`=10 while client 1 is WAITING -> no state change. `req`=01 while client 0 is SERVED -> `nextTicket` unchanged. `req`=`rel`=01 on the SERVED client -> client 0 ends IDLE and no new ticket is issued that cycle.
- Formal: with free `req`/`rel`, check onehot0(`grant`) and the `holders` invariant. Also check that every WAITING client is eventually granted, under fairness that SERVED clients eventually release.
